// File: rtl/key_input_ctrl_if.sv
// key_input_ctrl_if: the accepted-key channel from the button front-end to
// mainController.
//   key       : accepted 8-bit button pattern (registered by the producer)
//   key_valid : one-cycle strobe, new pattern accepted (or auto-repeat)
//   key_busy  : high while a candidate pattern is being debounced
// Modports: master = producer (key_input_ctrl), slave = consumer.
interface key_input_ctrl_if;
  logic [7:0] key;
  logic       key_valid;
  logic       key_busy;

  modport master (output key, output key_valid, output key_busy);
  modport slave  (input  key, input  key_valid, input  key_busy);
endinterface

// File: rtl/key_input_ctrl.sv
// key_input_ctrl: push-button front-end. Synchronizes eight raw button lines,
// debounces the whole vector as one pattern and presents a registered key
// pattern with a one-cycle strobe per accepted press.
// Ports:
//   clk     : system clock, rising edge
//   rst     : asynchronous active-high reset
//   key_raw : raw active-high buttons, asynchronous and bouncy
//   kif     : key_input_ctrl_if.master (key, key_valid, key_busy)
// Optional feature: define KEY_AUTOREPEAT_EN to make a held pattern strobe
// again after REP_DELAY_MS and then every REP_MS while it stays held.
module key_input_ctrl #(
  parameter int FRQ          = 1_000_000,
  parameter int DEB_MS       = 10,
  parameter int REP_DELAY_MS = 500,
  parameter int REP_MS       = 100
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              key_raw,
  key_input_ctrl_if.master        kif
);

  localparam int CYC_PER_MS    = FRQ / 1000;
  localparam int DEB_RAW       = CYC_PER_MS * DEB_MS;
  localparam int REP_DLY_RAW   = CYC_PER_MS * REP_DELAY_MS;
  localparam int REP_RAW       = CYC_PER_MS * REP_MS;
  localparam int DEB_CYC       = (DEB_RAW < 1) ? 1 : DEB_RAW;
  localparam int REP_DELAY_CYC = (REP_DLY_RAW < 1) ? 1 : REP_DLY_RAW;
  localparam int REP_CYC       = (REP_RAW < 1) ? 1 : REP_RAW;
  localparam int CNT_MAX_A     = (DEB_CYC > REP_CYC) ? DEB_CYC : REP_CYC;
  localparam int CNT_MAX       = (CNT_MAX_A > REP_DELAY_CYC) ? CNT_MAX_A : REP_DELAY_CYC;
  localparam int CNT_W         = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_TOP  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);
`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_DLY_LAST = CNT_W'(REP_DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST     = CNT_W'(REP_CYC - 1);
`endif

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    PRESSED   = 2'd2,
    DEB_REL   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       sync1_q, sync_q;
  logic [7:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_s;
  logic [7:0]       key_q, key_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
`ifdef KEY_AUTOREPEAT_EN
  logic             rep_q, rep_d;
  logic [CNT_W-1:0] rep_last_s;
`endif

  // Two-flop synchronizer per bit; everything downstream looks at sync_q only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 8'h00;
      sync_q  <= 8'h00;
    end else begin
      sync1_q <= key_raw;
      sync_q  <= sync1_q;
    end
  end

  // Saturating increment so the counter can never wrap back into a window.
  always_comb begin
    cnt_inc_s = cnt_q;
    if (cnt_q == CNT_TOP) begin
      cnt_inc_s = cnt_q;
    end else begin
      cnt_inc_s = cnt_q + CNT_W'(1);
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  // First repeat waits the long delay, later ones use the shorter period.
  always_comb begin
    rep_last_s = REP_DLY_LAST;
    if (rep_q) begin
      rep_last_s = REP_LAST;
    end else begin
      rep_last_s = REP_DLY_LAST;
    end
  end
`endif

  // Debounce FSM: next state, candidate, counter and output values.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    valid_d = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
    rep_d   = rep_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = CNT_ZERO;
        if (sync_q != 8'h00) begin
          cand_d  = sync_q;
          state_d = DEB_PRESS;
        end else begin
          state_d = IDLE;
        end
      end
      DEB_PRESS: begin
        if (sync_q != cand_q) begin
          // Any change restarts the window; all-zero abandons the press.
          // key keeps its old value here so a chord change never blanks it.
          cnt_d = CNT_ZERO;
          if (sync_q == 8'h00) begin
            state_d = IDLE;
          end else begin
            cand_d = sync_q;
          end
        end else if (cnt_q >= DEB_LAST) begin
          key_d   = cand_q;
          valid_d = 1'b1;
          cnt_d   = CNT_ZERO;
          state_d = PRESSED;
`ifdef KEY_AUTOREPEAT_EN
          rep_d   = 1'b0;
`endif
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      PRESSED: begin
        if (sync_q == key_q) begin
`ifdef KEY_AUTOREPEAT_EN
          if (cnt_q >= rep_last_s) begin
            valid_d = 1'b1;
            cnt_d   = CNT_ZERO;
            rep_d   = 1'b1;
          end else begin
            cnt_d = cnt_inc_s;
          end
`else
          cnt_d = CNT_ZERO;
`endif
        end else if (sync_q == 8'h00) begin
          cnt_d   = CNT_ZERO;
          state_d = DEB_REL;
        end else begin
          cand_d  = sync_q;
          cnt_d   = CNT_ZERO;
          state_d = DEB_PRESS;
        end
      end
      DEB_REL: begin
        if (sync_q != 8'h00) begin
          // Release was bounce: back to the held pattern without a strobe.
          cnt_d   = CNT_ZERO;
          state_d = PRESSED;
`ifdef KEY_AUTOREPEAT_EN
          rep_d   = 1'b0;
`endif
        end else if (cnt_q >= DEB_LAST) begin
          key_d   = 8'h00;
          cnt_d   = CNT_ZERO;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      default: begin
        cnt_d   = CNT_ZERO;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == DEB_PRESS) || (state_d == DEB_REL);
  end

  // FSM and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cand_q  <= 8'h00;
      cnt_q   <= CNT_ZERO;
      key_q   <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rep_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
`ifdef KEY_AUTOREPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign kif.key       = key_q;
  assign kif.key_valid = valid_q;
  assign kif.key_busy  = busy_q;

endmodule

// File: tb/tb_key_input_ctrl.sv
// tb_key_input_ctrl: self-checking bench for key_input_ctrl with a
// timestamp-based reference model, directed scenarios with hand-computed
// edge numbers, and a randomized phase with async reset pulses.
module tb_key_input_ctrl;
  localparam int DEB  = 100;
  localparam int RDLY = 500;
  localparam int RPER = 200;

  localparam int M_IDLE = 0;
  localparam int M_ON   = 1;
  localparam int M_HOLD = 2;
  localparam int M_OFF  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] key_raw = 8'hFF;

  key_input_ctrl_if kif ();

  key_input_ctrl #(
    .FRQ(100_000), .DEB_MS(1), .REP_DELAY_MS(5), .REP_MS(2)
  ) dut (
    .clk(clk), .rst(rst), .key_raw(key_raw), .kif(kif.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // reference model state
  int         m_edge = 0;
  int         rst_edge = 0;
  logic [7:0] raw_log [0:32767];
  int         mode = M_IDLE;
  logic [7:0] m_cand = 8'h00;
  logic [7:0] m_key = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_busy = 1'b0;
  int         t_start = 0;
  int         rep_due = 0;

  // strobe log from the DUT
  int n_strobes = 0;
  int last_strobe = -1;
  int strobe_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, m_edge, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: sync seen at edge e is the raw value sampled two edges
  // earlier; debounce windows are measured as edge-number differences.
  initial begin
    logic [7:0] s;
    forever begin
      @(posedge clk);
      m_edge++;
      raw_log[m_edge % 32768] = key_raw;
      if (rst) begin
        rst_edge = m_edge;
        mode = M_IDLE; m_key = 8'h00; m_cand = 8'h00;
        m_valid = 1'b0; m_busy = 1'b0;
      end else begin
        s = (m_edge - 2 > rst_edge) ? raw_log[(m_edge - 2) % 32768] : 8'h00;
        m_valid = 1'b0;
        case (mode)
          M_IDLE: if (s != 8'h00) begin m_cand = s; t_start = m_edge; mode = M_ON; end
          M_ON: begin
            if (s != m_cand) begin
              if (s == 8'h00) mode = M_IDLE;
              else begin m_cand = s; t_start = m_edge; end
            end else if (m_edge - t_start >= DEB) begin
              m_key = m_cand; m_valid = 1'b1; mode = M_HOLD; rep_due = m_edge + RDLY;
            end
          end
          M_HOLD: begin
            if (s == m_key) begin
`ifdef KEY_AUTOREPEAT_EN
              if (m_edge == rep_due) begin m_valid = 1'b1; rep_due = m_edge + RPER; end
`endif
            end else if (s == 8'h00) begin
              mode = M_OFF; t_start = m_edge;
            end else begin
              m_cand = s; t_start = m_edge; mode = M_ON;
            end
          end
          default: begin
            if (s != 8'h00) begin mode = M_HOLD; rep_due = m_edge + RDLY; end
            else if (m_edge - t_start >= DEB) begin m_key = 8'h00; mode = M_IDLE; end
          end
        endcase
        m_busy = (mode == M_ON) || (mode == M_OFF);
      end
    end
  end

  // Per-cycle compare of all outputs against the model, away from the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (kif.key_valid === 1'b1) begin
        n_strobes++;
        last_strobe = m_edge;
        strobe_q.push_back(m_edge);
      end
      chk("cycle{key,valid,busy}", {22'd0, kif.key, kif.key_valid, kif.key_busy},
          {22'd0, m_key, m_valid, m_busy});
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic run_to(input int x);
    while (m_edge < x) @(negedge clk);
    #1;
  endtask

  // Change key_raw on a falling edge; n is the first rising edge that sees it.
  task automatic drive(input logic [7:0] v, output int n);
    @(negedge clk);
    key_raw = v;
    n = m_edge + 1;
  endtask

  initial begin
    int n, m, l, g, r, s0;
    int exp_q [$];
    logic [7:0] v;
    int dur;

    // Reset with all buttons held.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_key", {24'd0, kif.key}, 32'h0);
    chk("rst_valid", {31'd0, kif.key_valid}, 32'h0);
    chk("rst_busy", {31'd0, kif.key_busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    n = m_edge + 1;
    run_to(n + 101);
    chk("rst_no_early_strobe", n_strobes, 0);
    run_to(n + 102);
    chk("rst_strobe_edge", last_strobe, n + 102);
    chk("rst_key_ff", {24'd0, kif.key}, 32'hFF);
    drive(8'h00, m);
    run_to(m + 101);
    chk("rel_ff_holds", {24'd0, kif.key}, 32'hFF);
    run_to(m + 102);
    chk("rel_ff_clear", {24'd0, kif.key}, 32'h0);
    chk("rel_ff_no_strobe", n_strobes, 1);

    // Clean press 8'h15 held 300 cycles.
    s0 = n_strobes;
    drive(8'h15, n);
    run_to(n + 102);
    chk("press15_edge", last_strobe, n + 102);
    chk("press15_key", {24'd0, kif.key}, 32'h15);
    run_to(n + 300);
    drive(8'h00, m);
    run_to(m + 102);
    chk("release15_key", {24'd0, kif.key}, 32'h0);
    chk("press15_one_strobe", n_strobes - s0, 1);

    // Bounce on bit 0 then settle high.
    s0 = n_strobes;
    for (int i = 0; i < 14; i++) begin
      drive((i % 2 == 0) ? 8'h01 : 8'h00, n);
      run_to(n + 29);
    end
    drive(8'h01, l);
    chk("bounce_quiet", n_strobes - s0, 0);
    run_to(l + 102);
    chk("bounce_edge", last_strobe, l + 102);
    chk("bounce_key", {24'd0, kif.key}, 32'h01);
    drive(8'h00, m);
    run_to(m + 110);

    // Chord change 8'h15 -> 8'h21 without release.
    drive(8'h15, n);
    run_to(n + 110);
    s0 = n_strobes;
    drive(8'h21, n);
    run_to(n + 101);
    chk("chord_old_key", {24'd0, kif.key}, 32'h15);
    chk("chord_no_early", n_strobes - s0, 0);
    run_to(n + 102);
    chk("chord_new_key", {24'd0, kif.key}, 32'h21);
    chk("chord_edge", last_strobe, n + 102);

    // Short release glitch while 8'h21 is held.
    s0 = n_strobes;
    drive(8'h00, g);
    run_to(g + 25);
    chk("glitch_busy", {31'd0, kif.key_busy}, 32'h1);
    chk("glitch_key", {24'd0, kif.key}, 32'h21);
    run_to(g + 49);
    drive(8'h21, r);
    run_to(r + 10);
    chk("glitch_key_after", {24'd0, kif.key}, 32'h21);
    chk("glitch_busy_after", {31'd0, kif.key_busy}, 32'h0);
    chk("glitch_no_strobe", n_strobes - s0, 0);
    drive(8'h00, m);
    run_to(m + 110);

    // Long hold of 8'h04: auto-repeat schedule.
    strobe_q.delete();
    drive(8'h04, n);
    run_to(n + 1250);
    drive(8'h00, m);
    run_to(m + 110);
`ifdef KEY_AUTOREPEAT_EN
    exp_q = '{n + 102, n + 602, n + 802, n + 1002, n + 1202};
`else
    exp_q = '{n + 102};
`endif
    chk("hold_strobe_count", strobe_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < strobe_q.size()) chk("hold_strobe_edge", strobe_q[i], exp_q[i]);
      else chk("hold_strobe_missing", 32'hFFFFFFFF, exp_q[i]);
    end

    // Randomized patterns, durations and async reset pulses.
    for (int it = 0; it < 70; it++) begin
      case ($urandom_range(0, 4))
        0: v = 8'h00;
        1: v = 8'h15;
        2: v = 8'h21;
        default: v = 8'($urandom_range(0, 255));
      endcase
      dur = ($urandom_range(0, 7) == 0) ? int'($urandom_range(500, 900))
                                        : int'($urandom_range(1, 250));
      drive(v, n);
      run_to(n + dur);
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_key", {24'd0, kif.key}, 32'h0);
        chk("async_rst_busy", {31'd0, kif.key_busy}, 32'h0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
      end
    end
    drive(8'h00, m);
    run_to(m + 110);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/key_input_ctrl.md
# key_input_ctrl

Front-end for the push-button bank feeding `mainController`. Synchronizes eight raw button lines, debounces the whole vector as one pattern, and presents a stable registered `key[7:0]` plus a one-cycle `key_valid` strobe per accepted press. It is the producer side of the `key` interface that `mainController` consumes; a piezo/display side is untouched.

## Interface
- `FRQ`, 1_000_000, clock frequency in Hz.
- `DEB_MS`, 10, debounce window in ms; `DEB_CYC = max(1, FRQ/1000*DEB_MS)` cycles.
- `REP_DELAY_MS`, 500, auto-repeat start delay in ms (used only with the macro).
- `REP_MS`, 100, auto-repeat period in ms (used only with the macro).
- `clk` in 1 system clock, all logic on rising edge.
- `rst` in 1 reset, asynchronous, active-high.
- `key_raw` in 8 raw buttons, active-high, asynchronous, bouncy.
- `key` out 8 accepted pattern to `mainController`; registered.
- `key_valid` out 1 one-cycle strobe: new pattern accepted (or repeat).
- `key_busy` out 1 high while a candidate pattern is being debounced.

## Operation
- Two-flop synchronizer per bit → `sync[7:0]`; all decisions use `sync` only.
- FSM states: IDLE, DEB_PRESS, PRESSED, DEB_REL.
- IDLE: `sync==0`. `sync!=0` → latch `cand=sync`, clear counter, go DEB_PRESS.
- DEB_PRESS: `sync!=cand` → if `sync==0` go IDLE, else `cand=sync`, counter cleared, stay. Counter reaching `DEB_CYC-1` with `sync==cand` → `key<=cand`, `key_valid=1`, go PRESSED.
- PRESSED: `sync==key` → hold. `sync==0` → counter cleared, go DEB_REL. Other nonzero `sync` (chord change) → `cand=sync`, go DEB_PRESS; `key` holds old value until new pattern accepted.
- DEB_REL: `sync!=0` → return PRESSED, no strobe (release was bounce). Stable zero for `DEB_CYC` cycles → `key<=0`, go IDLE; no strobe on release.
- `key_busy` = state is DEB_PRESS or DEB_REL.
- Counter width `$clog2(max(DEB_CYC, REP_CYC, REP_DELAY_CYC)+1)`; saturates, never wraps.
- Multi-key chords are legal; pattern is whole 8-bit vector, no priority encoding.

## Timing
- Reset: `key=0`, `key_valid=0`, `key_busy=0`, sync flops 0, counter 0, state IDLE. Reset mid-debounce or mid-press discards all state immediately (async).
- `key_raw` changes and stays stable before edge N → `sync` changes after edge N+1 → DEB_PRESS entered at edge N+2 → `key`/`key_valid` update at edge N+1+DEB_CYC+1 = N+DEB_CYC+2.
- Release stable before edge M → `key` clears at edge M+DEB_CYC+2.
- `key_valid` exactly one cycle high; never two consecutive cycles.
- Glitch shorter than DEB_CYC cycles of `sync` never produces `key_valid` nor changes `key`.
- `key` only ever changes on the same edge as a `key_valid` pulse, or to 0 on release acceptance.

## Configuration
- `KEY_AUTOREPEAT_EN` defined: in PRESSED, after `sync==key` stable `REP_DELAY_CYC=FRQ/1000*REP_DELAY_MS` cycles, `key_valid` pulses again, then every `REP_CYC=FRQ/1000*REP_MS` cycles while held; any exit from PRESSED cancels repeat; returning from DEB_REL restarts delay.
- Not defined: exactly one `key_valid` per accepted pattern; PRESSED counter unused; REP parameters ignored.

## Test plan
Bench: `FRQ=100_000`, `DEB_MS=1` (DEB_CYC=100), `REP_DELAY_MS=5` (500), `REP_MS=2` (200).
- Reset: `rst=1` with `key_raw=8'hFF` → `key=0`, `key_valid=0`, `key_busy=0`; deassert → `key=8'hFF`, one `key_valid` at 102nd edge.
- Clean press `8'h15` held 300 cycles, then release → `key=8'h15` with single strobe at edge N+102; `key=0` at release edge+102, no strobe.
- Bounce: toggle `key_raw[0]` every 30 cycles for 400 cycles then hold 1 → no strobe during bounce; one strobe and `key=8'h01` 102 cycles after last edge.
- Chord change `8'h15`→`8'h21` without release → `key` stays `8'h15` for 101 cycles, then `key=8'h21` with one strobe.
- Release glitch: while `key=8'h21`, drop to 0 for 50 cycles → `key` stays `8'h21`, no strobe, `key_busy` high during glitch.
- With `KEY_AUTOREPEAT_EN`: hold `8'h04` 1200 cycles → strobes at accept, +500, +700, +900, +1100; without macro → one strobe only.
